// File: rtl/uart_cmd_rx_pkg.sv
// Shared definitions for the UART command receiver: frame constants, FSM codes, checksum.
package uart_cmd_rx_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned FRAME_LEN     = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } bit_state_t;

    typedef enum logic [1:0] {
        P_SYNC,
        P_ADDR,
        P_DATA,
        P_CKS
    } parse_state_t;

    function automatic logic [7:0] frame_cksum(input logic [7:0] addr, input logic [31:0] data);
        return addr ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rxd synchroniser, mid-bit sampling bit FSM, framing check.
module uart_rx_byte
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic              rx_fall;
    logic              baud_tick;
    bit_state_t        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;

    // Synchroniser flops reset to the idle line level so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall   = rx_prev & ~rx_sync;
    assign baud_tick = (baud_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        baud_cnt <= BAUD_HALF;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (!rx_sync) begin
                            baud_cnt <= BAUD_FULL;
                            bit_cnt  <= '0;
                            state    <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shreg    <= {rx_sync, shreg[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        baud_cnt <= BAUD_FULL;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (baud_tick) begin
                        if (rx_sync) begin
                            byte_vld  <= 1'b1;
                            byte_data <= shreg;
                            state     <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_ONE;
                    end
                end
                WAIT_HI: begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command frame receiver: A5/addr/d3..d0/checksum frames become register-write strobes.
module uart_cmd_rx
    import uart_cmd_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned TIMEOUT_CLKS = 1000000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        byte_vld,
    output logic [7:0]  byte_data,
    output logic        wr_stb,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        frame_err,
    output logic        cksum_err,
    output logic        tmo_err,
    output logic        busy
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    parse_state_t     p_state;
    logic [1:0]       dcnt;
    logic [7:0]       sh_addr;
    logic [31:0]      sh_data;
    logic [TMO_W-1:0] tmo_cnt;
    logic [7:0]       cks_exp;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .frame_err(frame_err)
    );

    assign cks_exp = frame_cksum(sh_addr, sh_data);
    assign busy    = (p_state != P_SYNC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state   <= P_SYNC;
            dcnt      <= '0;
            sh_addr   <= '0;
            sh_data   <= '0;
            tmo_cnt   <= '0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cksum_err <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            cksum_err <= 1'b0;
            tmo_err   <= 1'b0;
            // A received byte takes priority over a timeout in the same cycle.
            if (byte_vld) begin
                tmo_cnt <= '0;
                case (p_state)
                    P_SYNC: begin
                        if (byte_data == SYNC_BYTE) begin
                            p_state <= P_ADDR;
                        end
                    end
                    P_ADDR: begin
                        sh_addr <= byte_data;
                        dcnt    <= '0;
                        p_state <= P_DATA;
                    end
                    P_DATA: begin
                        sh_data <= {sh_data[23:0], byte_data};
                        dcnt    <= dcnt + 2'd1;
                        if (dcnt == 2'd3) begin
                            p_state <= P_CKS;
                        end
                    end
                    P_CKS: begin
                        if (byte_data == cks_exp) begin
                            wr_addr <= sh_addr;
                            wr_data <= sh_data;
                            wr_stb  <= 1'b1;
                        end else begin
                            cksum_err <= 1'b1;
                        end
                        p_state <= P_SYNC;
                    end
                    default: p_state <= P_SYNC;
                endcase
            end else if (busy && frame_err) begin
                p_state <= P_SYNC;
                tmo_cnt <= '0;
            end else if (busy) begin
                if (tmo_cnt == TMO_LAST) begin
                    tmo_err <= 1'b1;
                    p_state <= P_SYNC;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_ONE;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial driver, byte/write scoreboards, event counters.
module tb_uart_cmd_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned TMO = 2000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic        byte_vld;
    logic [7:0]  byte_data;
    logic        wr_stb;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        frame_err;
    logic        cksum_err;
    logic        tmo_err;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_stb = 0, cnt_bvld = 0, cnt_cks = 0, cnt_tmo = 0, cnt_ferr = 0;
    int b_stb, b_bvld, b_cks, b_tmo, b_ferr;
    int waited;

    logic [39:0] exp_wr[$];
    logic [7:0]  exp_bytes[$];

    uart_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .frame_err(frame_err),
        .cksum_err(cksum_err),
        .tmo_err  (tmo_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] model_cks(input logic [7:0] a, input logic [31:0] d);
        logic [7:0] c = a;
        for (int i = 0; i < 4; i++) c ^= d[8*i +: 8];
        return c;
    endfunction

    function automatic logic [63:0] all_outputs();
        return 64'({byte_vld, byte_data, wr_stb, wr_addr, wr_data,
                    frame_err, cksum_err, tmo_err, busy});
    endfunction

    // Monitor: pops the scoreboards as the DUT produces bytes and writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_vld) begin
                cnt_bvld++;
                if (exp_bytes.size() == 0) check("byte_vld_unexpected", 64'(exp_bytes.size()), 64'd1);
                else check("byte_data", 64'(byte_data), 64'(exp_bytes.pop_front()));
            end
            if (wr_stb) begin
                cnt_stb++;
                if (exp_wr.size() == 0) check("wr_stb_unexpected", 64'(exp_wr.size()), 64'd1);
                else check("wr_addr_data", 64'({wr_addr, wr_data}), 64'(exp_wr.pop_front()));
            end
            if (cksum_err) cnt_cks++;
            if (tmo_err)   cnt_tmo++;
            if (frame_err) cnt_ferr++;
        end
    end

    task automatic mark();
        b_stb  = cnt_stb;
        b_bvld = cnt_bvld;
        b_cks  = cnt_cks;
        b_tmo  = cnt_tmo;
        b_ferr = cnt_ferr;
    endtask

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        send_bits(b);
        hold(1'b1, CPB);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] ck);
        if (ck == model_cks(a, d)) exp_wr.push_back({a, d});
        send_byte(8'hA5);
        send_byte(a);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        send_byte(ck);
        hold(1'b1, 3 * CPB);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b0;
        hold(1'b1, 5);
        check("idle_outputs", all_outputs(), 64'd0);

        // 1: good frame
        mark();
        send_frame(8'h03, 32'h12345678, model_cks(8'h03, 32'h12345678));
        check("t1_stb_count", 64'(cnt_stb - b_stb), 64'd1);
        check("t1_wr_addr", 64'(wr_addr), 64'h03);
        check("t1_wr_data", 64'(wr_data), 64'h12345678);
        check("t1_no_errors", 64'((cnt_cks - b_cks) + (cnt_tmo - b_tmo) + (cnt_ferr - b_ferr)), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // 2: bad checksum
        mark();
        send_frame(8'h03, 32'h12345678, model_cks(8'h03, 32'h12345678) ^ 8'h01);
        check("t2_cksum_err", 64'(cnt_cks - b_cks), 64'd1);
        check("t2_no_stb", 64'(cnt_stb - b_stb), 64'd0);
        check("t2_wr_hold", 64'({wr_addr, wr_data}), 64'h03_12345678);
        check("t2_busy", 64'(busy), 64'd0);

        // 3: leading junk bytes ignored
        mark();
        send_byte(8'h00);
        send_byte(8'hFF);
        check("t3_busy_after_junk", 64'(busy), 64'd0);
        send_frame(8'h03, 32'h12345678, model_cks(8'h03, 32'h12345678));
        check("t3_stb_count", 64'(cnt_stb - b_stb), 64'd1);
        check("t3_no_cksum_err", 64'(cnt_cks - b_cks), 64'd0);

        // 4: inter-byte timeout, then recovery
        mark();
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h12);
        check("t4_busy_mid_frame", 64'(busy), 64'd1);
        waited = 0;
        while (cnt_tmo == b_tmo && waited < int'(TMO) + 500) begin
            @(negedge clk);
            waited++;
        end
        check("t4_tmo_err", 64'(cnt_tmo - b_tmo), 64'd1);
        check("t4_tmo_not_early", 64'(waited >= int'(TMO - CPB)), 64'd1);
        @(negedge clk);
        check("t4_busy_dropped", 64'(busy), 64'd0);
        check("t4_no_stb", 64'(cnt_stb - b_stb), 64'd0);
        send_frame(8'h5A, 32'hDEADBEEF, model_cks(8'h5A, 32'hDEADBEEF));
        check("t4_recover_stb", 64'(cnt_stb - b_stb), 64'd1);
        check("t4_recover_wr", 64'({wr_addr, wr_data}), 64'h5A_DEADBEEF);

        // 5: stop bit held low, then a clean byte
        mark();
        send_bits(8'h55);
        hold(1'b0, 3 * CPB);
        hold(1'b1, 2 * CPB);
        check("t5_frame_err", 64'(cnt_ferr - b_ferr), 64'd1);
        check("t5_no_byte_vld", 64'(cnt_bvld - b_bvld), 64'd0);
        send_byte(8'h5A);
        hold(1'b1, CPB);
        check("t5_next_byte_vld", 64'(cnt_bvld - b_bvld), 64'd1);
        check("t5_byte_data", 64'(byte_data), 64'h5A);
        check("t5_ferr_once", 64'(cnt_ferr - b_ferr), 64'd1);

        // 6: short glitch, then reset in the middle of a byte inside a frame
        mark();
        hold(1'b0, 4);
        hold(1'b1, 3 * CPB);
        check("t6_glitch_no_byte", 64'(cnt_bvld - b_bvld), 64'd0);
        check("t6_glitch_no_ferr", 64'(cnt_ferr - b_ferr), 64'd0);
        send_byte(8'hA5);
        send_byte(8'h03);
        check("t6_busy_before_rst", 64'(busy), 64'd1);
        hold(1'b0, 3 * CPB);
        rst = 1'b1;
        #1;
        check("t6_rst_outputs", all_outputs(), 64'd0);
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 2 * CPB);
        mark();
        send_frame(8'hC7, 32'h01020304, model_cks(8'hC7, 32'h01020304));
        check("t6_post_rst_stb", 64'(cnt_stb - b_stb), 64'd1);
        check("t6_post_rst_wr", 64'({wr_addr, wr_data}), 64'hC7_01020304);
        check("t6_no_errors", 64'((cnt_cks - b_cks) + (cnt_tmo - b_tmo) + (cnt_ferr - b_ferr)), 64'd0);

        check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
        check("byte_queue_drained", 64'(exp_bytes.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
